// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state types for the FFT input framer
// Contents:
//   FFT_NUM_LANES, FFT_BLOCKS, FFT_IN_WIDTH  default framer geometry (512-pt = 16 x 32)
//   bank_state_e                             per-bank occupancy: EMPTY, FILLING, FULL, DRAINING
//   rd_state_e                               read FSM state: IDLE, BURST
package fft_pkg;

    localparam int FFT_NUM_LANES = 16;
    localparam int FFT_BLOCKS    = 32;
    localparam int FFT_IN_WIDTH  = 9;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/framer_bank.sv
// rtl/framer_bank.sv - one frame of complex lane words, sync write / comb read
// Ports:
//   clk              rising-edge clock for the write port
//   we               write enable
//   waddr            word address written when we=1
//   wdata_i/wdata_q  packed real/imag lanes to store
//   raddr            word address read combinationally
//   rdata_i/rdata_q  packed real/imag lanes at raddr
module framer_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_IN_WIDTH,
    parameter int NUM_LANES  = FFT_NUM_LANES,
    parameter int BLOCKS     = FFT_BLOCKS
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [$clog2(BLOCKS)-1:0]         waddr,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]   wdata_i,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]   wdata_q,
    input  logic [$clog2(BLOCKS)-1:0]         raddr,
    output logic [DATA_WIDTH*NUM_LANES-1:0]   rdata_i,
    output logic [DATA_WIDTH*NUM_LANES-1:0]   rdata_q
);

    logic [DATA_WIDTH*NUM_LANES-1:0] mem_i [BLOCKS];
    logic [DATA_WIDTH*NUM_LANES-1:0] mem_q [BLOCKS];

    // Storage carries no reset: contents are only ever read after the bank
    // state says a full frame has been written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_i[waddr] <= wdata_i;
            mem_q[waddr] <= wdata_q;
        end
    end

    assign rdata_i = mem_i[raddr];
    assign rdata_q = mem_q[raddr];

endmodule

// File: rtl/fft_in_framer.sv
// rtl/fft_in_framer.sv - ping-pong frame buffer emitting gapless alert-framed bursts
// Optional feature macro: FFT_FRAMER_DBG_EN (adds frame_cnt and sof_drop outputs)
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   din_valid/din_sof  input word valid / word is frame start
//   din_i/din_q        packed signed lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   din_ready          a word is accepted this cycle when din_valid=1
//   dout_i/dout_q      registered burst lanes (0 while dout_valid=0)
//   dout_valid         burst word valid
//   alert_out          one-cycle pulse with burst word 0
//   frame_cnt          (debug) count of alert pulses, wraps at 16 bits
//   sof_drop           (debug) pulse when a partial frame is discarded by din_sof
module fft_in_framer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_IN_WIDTH,
    parameter int NUM_LANES  = FFT_NUM_LANES,
    parameter int BLOCKS     = FFT_BLOCKS
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              din_valid,
    input  logic                              din_sof,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]   din_i,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]   din_q,
    output logic                              din_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0]   dout_i,
    output logic [DATA_WIDTH*NUM_LANES-1:0]   dout_q,
    output logic                              dout_valid,
    output logic                              alert_out
`ifdef FFT_FRAMER_DBG_EN
    ,
    output logic [15:0]                       frame_cnt,
    output logic [0:0]                        sof_drop
`endif
);

    localparam int AW = $clog2(BLOCKS);
    localparam int WW = DATA_WIDTH * NUM_LANES;
    localparam logic [AW-1:0] LAST_ADDR = AW'(BLOCKS - 1);

    bank_state_e   bank_st  [2];
    bank_state_e   bank_nxt [2];
    rd_state_e     rd_state;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    logic          accept;
    logic          sof_restart;
    logic [AW-1:0] wr_ptr;
    logic          wr_last;
    logic          rd_go;
    logic          rd_last;

    logic [WW-1:0] b0_rdata_i, b0_rdata_q, b1_rdata_i, b1_rdata_q;
    logic [WW-1:0] rd_data_i, rd_data_q;

    assign din_ready   = (bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING);
    assign accept      = din_valid && din_ready;
    // A mid-frame SOF restarts the same bank at address 0.
    assign sof_restart = accept && din_sof && (wr_addr != '0);
    assign wr_ptr      = sof_restart ? '0 : wr_addr;
    assign wr_last     = accept && (wr_ptr == LAST_ADDR);

    // Reading starts in the same cycle the current bank is seen FULL, so the
    // first burst word lands one edge after the last write.
    assign rd_go   = (rd_state == BURST) || (bank_st[rd_bank] == FULL);
    assign rd_last = rd_go && (rd_addr == LAST_ADDR);

    assign rd_data_i = rd_bank ? b1_rdata_i : b0_rdata_i;
    assign rd_data_q = rd_bank ? b1_rdata_q : b0_rdata_q;

    // Writes only target EMPTY/FILLING banks and reads only FULL/DRAINING
    // ones, so the two updates never land on the same bank in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nxt[b] = bank_st[b];
            if (accept && (wr_bank == 1'(b))) begin
                bank_nxt[b] = wr_last ? FULL : FILLING;
            end
            if (rd_go && (rd_bank == 1'(b))) begin
                if (rd_last) begin
                    bank_nxt[b] = EMPTY;
                end else if (rd_addr == '0) begin
                    bank_nxt[b] = DRAINING;
                end
            end
        end
    end

    framer_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES),
        .BLOCKS     (BLOCKS)
    ) u_bank0 (
        .clk     (clk),
        .we      (accept && !wr_bank),
        .waddr   (wr_ptr),
        .wdata_i (din_i),
        .wdata_q (din_q),
        .raddr   (rd_addr),
        .rdata_i (b0_rdata_i),
        .rdata_q (b0_rdata_q)
    );

    framer_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES),
        .BLOCKS     (BLOCKS)
    ) u_bank1 (
        .clk     (clk),
        .we      (accept && wr_bank),
        .waddr   (wr_ptr),
        .wdata_i (din_i),
        .wdata_q (din_q),
        .raddr   (rd_addr),
        .rdata_i (b1_rdata_i),
        .rdata_q (b1_rdata_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_state   <= IDLE;
            dout_i     <= '0;
            dout_q     <= '0;
            dout_valid <= 1'b0;
            alert_out  <= 1'b0;
`ifdef FFT_FRAMER_DBG_EN
            frame_cnt  <= '0;
            sof_drop   <= 1'b0;
`endif
        end else begin
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];

            if (accept) begin
                // BLOCKS is a power of two, so LAST_ADDR + 1 wraps to 0.
                wr_addr <= wr_ptr + AW'(1);
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (rd_go) begin
                rd_addr <= rd_addr + AW'(1);
                if (rd_last) begin
                    rd_bank  <= ~rd_bank;
                    // Stay in BURST when the other bank is (or just became)
                    // full: back-to-back frames with no gap.
                    rd_state <= (bank_nxt[~rd_bank] == FULL) ? BURST : IDLE;
                end else begin
                    rd_state <= BURST;
                end
            end

            dout_valid <= rd_go;
            alert_out  <= rd_go && (rd_addr == '0);
            dout_i     <= rd_go ? rd_data_i : '0;
            dout_q     <= rd_go ? rd_data_q : '0;
`ifdef FFT_FRAMER_DBG_EN
            if (rd_go && (rd_addr == '0)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            sof_drop <= sof_restart;
`endif
        end
    end

endmodule

// File: tb/tb_fft_in_framer.sv
// tb/tb_fft_in_framer.sv - self-checking bench for fft_in_framer
module tb_fft_in_framer;
    import fft_pkg::*;

    localparam int DW = FFT_IN_WIDTH;
    localparam int NL = FFT_NUM_LANES;
    localparam int NB = FFT_BLOCKS;
    localparam int WW = DW * NL;

    logic          clk = 1'b0;
    logic          rstn;
    logic          din_valid;
    logic          din_sof;
    logic [WW-1:0] din_i, din_q;
    logic          din_ready;
    logic [WW-1:0] dout_i, dout_q;
    logic          dout_valid;
    logic          alert_out;
`ifdef FFT_FRAMER_DBG_EN
    logic [15:0]   frame_cnt;
    logic [0:0]    sof_drop;
`endif

    always #5 clk = ~clk;

    fft_in_framer dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_i      (din_i),
        .din_q      (din_q),
        .din_ready  (din_ready),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_valid (dout_valid),
        .alert_out  (alert_out)
`ifdef FFT_FRAMER_DBG_EN
        ,
        .frame_cnt  (frame_cnt),
        .sof_drop   (sof_drop)
`endif
    );

    typedef struct {
        logic [WW-1:0] i;
        logic [WW-1:0] q;
    } word_t;

    typedef struct {
        int n_words;
        int gap;
        int sof_at;
        int mode;
        int exp_alerts;
        int exp_valid;
        int exp_delay;
    } vec_t;

    word_t outq[$];
    word_t part[$];
    int    out_pos;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    n_alert, n_valid, first_acc, first_alert;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic word_t mk_word(input int mode, input int n);
        word_t w;
        for (int k = 0; k < NL; k++) begin
            case (mode)
                0: begin
                    w.i[k*DW +: DW] = DW'(n * 16 + k);
                    w.q[k*DW +: DW] = DW'(-(n * 16 + k));
                end
                1: begin
                    w.i[k*DW +: DW] = DW'(12'h0AA);
                    w.q[k*DW +: DW] = DW'(12'h0AA);
                end
                2: begin
                    w.i[k*DW +: DW] = ((k + n) % 2 == 0) ? DW'(-256) : DW'(255);
                    w.q[k*DW +: DW] = ((k + n) % 2 == 0) ? DW'(255) : DW'(-256);
                end
                default: begin
                    w.i[k*DW +: DW] = DW'($urandom);
                    w.q[k*DW +: DW] = DW'($urandom);
                end
            endcase
        end
        return w;
    endfunction

    task automatic model_reset();
        outq.delete();
        part.delete();
        out_pos     = 0;
        n_alert     = 0;
        n_valid     = 0;
        first_acc   = -1;
        first_alert = -1;
    endtask

    // One clock: drive inputs, advance the frame-queue model, compare outputs.
    // Whole frames enter outq when their last word is accepted; a word leaves
    // outq on every edge where outq was non-empty before that edge.
    task automatic step(input logic v, input logic s, input word_t w, output logic acc);
        logic  emit;
        word_t e;
        int    held;
        e.i = '0;
        e.q = '0;
        din_valid = v;
        din_sof   = s;
        din_i     = w.i;
        din_q     = w.q;
        @(negedge clk);
        acc  = v && din_ready;
        emit = (outq.size() > 0);
        @(posedge clk);
        #1;
        cyc++;
        if (emit) e = outq.pop_front();
        if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            if (s && part.size() > 0) part.delete();
            part.push_back(w);
            if (part.size() == NB) begin
                foreach (part[j]) outq.push_back(part[j]);
                part.delete();
            end
        end
        chk("dout_valid", WW'(dout_valid), WW'(emit));
        chk("alert_out", WW'(alert_out), WW'(emit && (out_pos % NB == 0)));
        chk("dout_i", dout_i, emit ? e.i : '0);
        chk("dout_q", dout_q, emit ? e.q : '0);
        if (emit) begin
            if (out_pos % NB == 0) begin
                n_alert++;
                if (first_alert < 0) first_alert = cyc;
            end
            n_valid++;
            out_pos++;
        end
        held = (outq.size() + NB - 1) / NB;
        chk("din_ready", WW'(din_ready), WW'(held < 2));
    endtask

    task automatic idle(input int n);
        logic a;
        word_t z;
        z.i = '0;
        z.q = '0;
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, z, a);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        din_i     = '0;
        din_q     = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_dout_valid", WW'(dout_valid), '0);
        chk("rst_alert", WW'(alert_out), '0);
        chk("rst_dout_i", dout_i, '0);
        chk("rst_din_ready", WW'(din_ready), WW'(1));
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        logic  a;
        word_t w;
        int    sent, t, guard;

        vecs[0] = '{64, 0, -1, 0, 2, 64, 32};
        vecs[1] = '{32, 1, -1, 0, 1, 32, 63};
        vecs[2] = '{96, 0, -1, 0, 3, 96, 32};
        vecs[3] = '{42, 0, 10, 0, 1, 32, 42};
        vecs[4] = '{96, 0, -1, 2, 3, 96, 32};

        for (int r = 0; r < 5; r++) begin
            do_reset();
            sent = 0;
            t    = 0;
            while (sent < vecs[r].n_words && t < 400) begin
                if (vecs[r].gap != 0 && (t % 2 == 1)) begin
                    idle(1);
                end else begin
                    w = (sent == vecs[r].sof_at) ? mk_word(1, 0) : mk_word(vecs[r].mode, sent);
                    step(1'b1, sent == vecs[r].sof_at, w, a);
                    if (a) sent++;
                end
                t++;
            end
            idle(80);
            chk($sformatf("row%0d_alerts", r), WW'(n_alert), WW'(vecs[r].exp_alerts));
            chk($sformatf("row%0d_valid_words", r), WW'(n_valid), WW'(vecs[r].exp_valid));
            chk($sformatf("row%0d_first_alert_delay", r), WW'(first_alert - first_acc), WW'(vecs[r].exp_delay));
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        for (int n = 0; n < NB; n++) step(1'b1, 1'b0, mk_word(0, n), a);
        guard = 0;
        while (out_pos < 16 && guard < 60) begin
            idle(1);
            guard++;
        end
        chk("reach_burst_word15", WW'(out_pos), WW'(16));
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_dout_valid", WW'(dout_valid), '0);
        chk("async_rst_alert", WW'(alert_out), '0);
        chk("async_rst_dout_i", dout_i, '0);
        chk("async_rst_dout_q", dout_q, '0);
        chk("async_rst_din_ready", WW'(din_ready), WW'(1));
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(40);
        chk("post_rst_no_output", WW'(n_valid), '0);
        for (int n = 0; n < NB; n++) step(1'b1, 1'b0, mk_word(3, n), a);
        idle(40);
        chk("post_rst_alerts", WW'(n_alert), WW'(1));
        chk("post_rst_valid_words", WW'(n_valid), WW'(NB));

        // Randomized traffic with occasional SOF restarts.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, mk_word(3, c), a);
        end
        idle(80);
        chk("random_drained", WW'(outq.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
